mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between an instruction-fetch requester (I)
//   and a data requester (D). Only one bus transaction is outstanding at a
//   time. Grants are issued combinationally while idle; the winner's request
//   is registered onto the m_* port and held until the memory accepts it.
//   Completion data is registered back to the owning side with a one-cycle
//   rvalid pulse. A fetch flushed while in flight still completes on the bus
//   but its i_rvalid pulse is suppressed.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   i_req, i_addr, i_flush   fetch request, address, jump-taken discard
//   i_gnt, i_rvalid, i_rdata fetch grant, data valid pulse, data
//   d_req, d_we, d_addr,     data request, write enable, address,
//   d_wdata, d_wstrb         write data, byte enables
//   d_gnt, d_rvalid, d_rdata data grant, completion pulse, read data
//   m_req, m_we, m_addr,     memory request (registered), write enable,
//   m_wdata, m_wstrb         address, write data, byte enables
//   m_ack, m_rvalid, m_rdata memory accept, completion, read data
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_flush,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_ack,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic grant_i;
   logic grant_d;
   logic complete;
   logic flush_hit;
   logic last_d;    // 1: D won the most recent grant, 0: I did
   logic owner_d;   // side that owns the outstanding transaction
   logic drop;      // in-flight fetch has been flushed

   // Arbitration and sequencing. Grants exist only in IDLE; on contention
   // the side that did not win last time is chosen.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            grant_d = d_req && (!i_req || !last_d);
            grant_i = i_req && !grant_d;
            if (grant_i || grant_d) state_nxt = ISSUE;
         end
         ISSUE: begin
            // m_rvalid only counts here when the accept arrives with it
            if (m_ack) begin
               if (m_rvalid) begin
                  complete  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (m_rvalid) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign i_gnt = grant_i;
   assign d_gnt = grant_d;

   // A flush marks the fetch as dropped if I owns the bus or is being
   // granted this very cycle; it never touches a D transaction.
   assign flush_hit = i_flush && (grant_i || ((state != IDLE) && !owner_d));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d   <= 1'b0;
         owner_d  <= 1'b0;
         drop     <= 1'b0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_wstrb  <= '0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         // Request stays up for every ISSUE cycle and falls after the accept
         m_req    <= (state_nxt == ISSUE);

         if (grant_i || grant_d) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            if (grant_d) begin
               m_we    <= d_we;
               m_addr  <= d_addr;
               m_wdata <= d_wdata;
               m_wstrb <= d_wstrb;
            end else begin
               m_we    <= 1'b0;
               m_addr  <= i_addr;
               m_wdata <= '0;
               m_wstrb <= '1;
            end
         end

         if (complete) begin
            drop <= 1'b0;
            if (owner_d) begin
               d_rvalid <= 1'b1;
               // m_we still reflects the owner's request; writes return zero
               d_rdata  <= m_we ? '0 : m_rdata;
            end else if (!(drop || i_flush)) begin
               i_rvalid <= 1'b1;
               i_rdata  <= m_rdata;
            end
         end else if (flush_hit) begin
            drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a vector table of single-side
//   transactions, a contention sequence and a stall/reset sequence. Expected
//   completions are queued when a grant is expected and popped when an
//   rvalid pulse is seen.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_flush;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ack;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          ack_dly;   // ISSUE cycles without m_ack before the accept
      int          rv_dly;    // WAIT cycles until m_rvalid (0: with the accept)
      int          flush;     // 0 none, 1 at grant, 2 first WAIT cycle, 3 at rvalid out
      logic [31:0] mem_rdata;
      bit          exp_we;
      logic [3:0]  exp_strb;
      logic [31:0] exp_rdata;
      bit          exp_deliver;
   } vec_t;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
   } sb_t;

   sb_t         sb[$];
   int          vectors;
   int          miscompares;
   logic [31:0] last_i;
   logic [31:0] last_d;
   bit          i_known;
   vec_t        tbl[12];

   function automatic vec_t mk(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] strb, int ack_dly, int rv_dly, int flush,
                               logic [31:0] mem_rdata, bit exp_we, logic [3:0] exp_strb,
                               logic [31:0] exp_rdata, bit exp_deliver);
      vec_t v;
      v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.ack_dly = ack_dly; v.rv_dly = rv_dly; v.flush = flush; v.mem_rdata = mem_rdata;
      v.exp_we = exp_we; v.exp_strb = exp_strb; v.exp_rdata = exp_rdata;
      v.exp_deliver = exp_deliver;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: any rvalid pulse must match the oldest expected completion
   task automatic monitor();
      sb_t e;
      if (i_rvalid || d_rvalid) begin
         if (i_rvalid && d_rvalid) begin
            check("rvalid_both", {i_rvalid, d_rvalid}, 2'b01);
         end else if (sb.size() == 0) begin
            check("rvalid_unexpected", {i_rvalid, d_rvalid}, 2'b00);
         end else begin
            e = sb.pop_front();
            check("rvalid_side", d_rvalid, e.is_d);
            check("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            if (e.is_d) last_d = e.rdata;
            else begin
               last_i  = e.rdata;
               i_known = 1'b1;
            end
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      monitor();
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input vec_t v);
      sb_t e;
      // grant cycle
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.strb;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      i_flush = (v.flush == 1);
      sample();
      check("gnt", {i_gnt, d_gnt}, v.is_d ? 2'b01 : 2'b10);
      if (v.exp_deliver) begin
         e.is_d  = v.is_d;
         e.rdata = v.exp_rdata;
         sb.push_back(e);
      end
      next();
      i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
      // stalled ISSUE cycles
      for (int k = 0; k < v.ack_dly; k++) begin
         m_ack = 1'b0;
         sample();
         check("stall_m_req", m_req, 1'b1);
         check("stall_m_addr", m_addr, v.addr);
         check("stall_gnt", {i_gnt, d_gnt}, 2'b00);
         next();
      end
      // accept cycle
      m_ack    = 1'b1;
      m_rvalid = (v.rv_dly == 0);
      m_rdata  = (v.rv_dly == 0) ? v.mem_rdata : 32'h0;
      sample();
      check("m_req", m_req, 1'b1);
      check("m_addr", m_addr, v.addr);
      check("m_we", m_we, v.exp_we);
      check("m_wstrb", m_wstrb, v.exp_strb);
      if (v.is_d) check("m_wdata", m_wdata, v.wdata);
      next();
      m_ack = 1'b0; m_rvalid = 1'b0;
      // WAIT cycles
      for (int j = 1; j <= v.rv_dly; j++) begin
         i_flush  = (v.flush == 2 && j == 1);
         m_rvalid = (j == v.rv_dly);
         m_rdata  = (j == v.rv_dly) ? v.mem_rdata : 32'h0;
         sample();
         check("wait_m_req", m_req, 1'b0);
         next();
      end
      i_flush = 1'b0; m_rvalid = 1'b0;
      // completion output cycle
      i_flush = (v.flush == 3);
      sample();
      check("sb_empty", sb.size(), 0);
      sb.delete();
      check("nonowner_rvalid", v.is_d ? i_rvalid : d_rvalid, 1'b0);
      if (!v.exp_deliver) check("dropped_i_rvalid", i_rvalid, 1'b0);
      if (v.is_d) begin
         if (i_known) check("hold_i_rdata", i_rdata, last_i);
      end else begin
         check("hold_d_rdata", d_rdata, last_d);
      end
      if (!v.is_d && !v.exp_deliver) i_known = 1'b0;
      next();
      i_flush = 1'b0;
   endtask

   initial begin
      sb_t         e;
      int          gcount;
      logic [31:0] pend;

      vectors = 0; miscompares = 0;
      last_i = 32'h0; last_d = 32'h0; i_known = 1'b1;
      rst = 1'b1;
      i_req = 0; i_addr = 0; i_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      m_ack = 0; m_rvalid = 0; m_rdata = 0;

      //       is_d we addr          wdata         strb  ack rv fl mem_rdata     we strb  exp_rdata     del
      tbl[0]  = mk(0, 0, 32'h100,      32'h0,        4'hF, 0, 1, 0, 32'h00000013, 0, 4'hF, 32'h00000013, 1);
      tbl[1]  = mk(1, 1, 32'h2000,     32'hDEADBEEF, 4'h3, 0, 0, 0, 32'h77777777, 1, 4'h3, 32'h0,        1);
      tbl[2]  = mk(1, 0, 32'h2004,     32'h0,        4'hF, 2, 2, 0, 32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 1);
      tbl[3]  = mk(0, 0, 32'h104,      32'h0,        4'h0, 1, 0, 0, 32'h12345678, 0, 4'hF, 32'h12345678, 1);
      tbl[4]  = mk(0, 0, 32'h108,      32'h0,        4'h0, 0, 3, 2, 32'hBADBAD00, 0, 4'hF, 32'hBADBAD00, 0);
      tbl[5]  = mk(0, 0, 32'h10C,      32'h0,        4'h0, 0, 1, 0, 32'h00A00093, 0, 4'hF, 32'h00A00093, 1);
      tbl[6]  = mk(0, 0, 32'h110,      32'h0,        4'h0, 0, 1, 1, 32'h11111111, 0, 4'hF, 32'h11111111, 0);
      tbl[7]  = mk(0, 0, 32'h114,      32'h0,        4'h0, 0, 1, 3, 32'h22222222, 0, 4'hF, 32'h22222222, 1);
      tbl[8]  = mk(1, 0, 32'h3000,     32'h0,        4'hF, 0, 2, 2, 32'h33333333, 0, 4'hF, 32'h33333333, 1);
      tbl[9]  = mk(1, 1, 32'h3004,     32'h01020304, 4'hF, 5, 1, 0, 32'h44444444, 1, 4'hF, 32'h0,        1);
      tbl[10] = mk(0, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 0, 0, 32'hFFFFFFFF, 0, 4'hF, 32'hFFFFFFFF, 1);
      tbl[11] = mk(1, 1, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h55555555, 1, 4'h0, 32'h0,        1);

      // reset state
      sample();
      check("rst_m_req", m_req, 1'b0);
      check("rst_m_we", m_we, 1'b0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_wdata", m_wdata, 32'h0);
      check("rst_m_wstrb", m_wstrb, 4'h0);
      check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      next();
      rst = 1'b0;

      // contention: first grant to D, then strict alternation
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h400;
      d_we = 1'b0; d_wstrb = 4'hF;
      gcount = 0; pend = 32'h0;
      for (int c = 0; c < 9; c++) begin
         m_ack    = m_req;
         m_rvalid = m_req;
         m_rdata  = pend;
         sample();
         if (i_gnt || d_gnt) begin
            check("cont_onehot", {i_gnt, d_gnt} == 2'b11, 1'b0);
            check("cont_side_d", d_gnt, (gcount % 2) == 0);
            pend    = 32'h1000 + gcount;
            e.is_d  = ((gcount % 2) == 0);
            e.rdata = pend;
            sb.push_back(e);
            gcount++;
         end
         next();
         if (gcount == 4) begin
            i_req = 1'b0; d_req = 1'b0;
         end
      end
      m_ack = 1'b0; m_rvalid = 1'b0;
      check("cont_grants", gcount, 4);
      check("cont_sb_empty", sb.size(), 0);
      sb.delete();

      // single-side vectors
      for (int n = 0; n < 12; n++) run(tbl[n]);

      // stall in ISSUE, then reset mid-transaction
      i_req = 1'b1; i_addr = 32'h500;
      sample();
      check("stall_gnt_i", i_gnt, 1'b1);
      next();
      i_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         m_ack = 1'b0;
         sample();
         check("rst_stall_m_req", m_req, 1'b1);
         check("rst_stall_m_addr", m_addr, 32'h500);
         next();
      end
      rst = 1'b1;
      #1;
      check("async_rst_m_req", m_req, 1'b0);
      check("async_rst_m_addr", m_addr, 32'h0);
      sample();
      next();
      rst = 1'b0;
      last_i = 32'h0; last_d = 32'h0; i_known = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample();
         check("post_rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
         next();
      end
      // after reset the arbiter is idle and the first contention goes to D
      i_req = 1'b1; d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
      sample();
      check("post_rst_gnt", {i_gnt, d_gnt}, 2'b01);
      e.is_d = 1'b1; e.rdata = 32'h66666666;
      sb.push_back(e);
      next();
      i_req = 1'b0; d_req = 1'b0;
      m_ack = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h66666666;
      sample();
      check("post_rst_m_addr", m_addr, 32'h600);
      next();
      m_ack = 1'b0; m_rvalid = 1'b0;
      sample();
      check("post_rst_sb_empty", sb.size(), 0);
      next();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
